div_unit: RTL

- Iterative restoring divider. It serves as the inverse companion to the core add/subtract ALU and backs the 45GS02-style math register block.
- Accepts a dividend/divisor pair on a start pulse and retires one quotient bit per enabled cycle.
- Presents quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Stalls with the CPU `ready` qualifier, as the flag units do.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_WIDTH_DEF : default operand/result width
//   div_state_e   : controller state encoding (IDLE / RUN / FIN), 2 bits
package div_unit_pkg;

    localparam int DIV_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        kDIV_IDLE = 2'd0,
        kDIV_RUN  = 2'd1,
        kDIV_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   rem_i  : partial remainder (always < dvs_i)
//   bit_i  : next dividend bit shifted in at the bottom
//   dvs_i  : divisor magnitude
//   rem_o  : next partial remainder
//   qbit_o : quotient bit retired by this step
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The full remainder is kept in the shift so divisors above half range
    // stay exact. Because rem_i < dvs_i, shifted < 2*dvs_i, so the trial
    // difference fits WIDTH+1 bits and its top bit is a clean borrow flag.
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {1'b0, dvs_i};
    assign qbit_o  = ~trial[WIDTH];
    assign rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per enabled cycle.
//   clk, reset_n     : clock, asynchronous active-low reset
//   ready            : global clock enable, all state holds while low
//   start, signed_op : request and operand mode, sampled when idle/finished
//   dividend, divisor: operands, sampled with start
//   busy, done       : operation in progress / one-cycle result-valid pulse
//   quotient, remainder, div_by_zero : results, held until the next result
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ready,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg2(x) : x;
    endfunction

    // Control and visible results
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             corr_q, corr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // Datapath working registers
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        corr_d      = corr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        negq_d      = negq_q;
        negr_d      = negr_q;

        if (ready) begin
            case (state_q)
                kDIV_IDLE, kDIV_FIN: begin
                    state_d = kDIV_IDLE;
                    if (start) begin
                        rem_d  = '0;
                        quo_d  = mag(dividend, signed_op);
                        dvs_d  = mag(divisor, signed_op);
                        negq_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        negr_d = signed_op & dividend[WIDTH-1];
                        cnt_d  = CNT_LOAD;
                        corr_d = 1'b0;
                        if (divisor == '0) begin
                            state_d     = kDIV_FIN;
                            quotient_d  = '1;
                            remainder_d = dividend;
                            dbz_d       = 1'b1;
                        end else begin
                            state_d = kDIV_RUN;
                        end
                    end
                end
                kDIV_RUN: begin
                    // After the last quotient bit, one more cycle applies the
                    // sign fix-up and publishes the results; busy is already
                    // low then, but a start in that cycle is not accepted.
                    if (corr_q) begin
                        state_d     = kDIV_FIN;
                        corr_d      = 1'b0;
                        quotient_d  = negq_q ? neg2(quo_q) : quo_q;
                        remainder_d = negr_q ? neg2(rem_q) : rem_q;
                        dbz_d       = 1'b0;
                    end else begin
                        rem_d = step_rem;
                        // Dividend bits leave at the top while quotient bits
                        // enter at the bottom of the same register.
                        quo_d = {quo_q[WIDTH-2:0], step_qbit};
                        if (cnt_q == '0) begin
                            corr_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = kDIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= kDIV_IDLE;
            cnt_q       <= '0;
            corr_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            corr_q      <= corr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

    assign busy        = (state_q == kDIV_RUN) && !corr_q;
    assign done        = (state_q == kDIV_FIN);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
